// File: rtl/decode_execute_pipe_if.sv
// Handshake bundle for decode_execute_pipe: register-file load port, instruction
// issue port and result port. The block under test connects through the slave modport.
interface decode_execute_pipe_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREG  = 4
);
   localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

   logic             ld_en;
   logic [AW-1:0]    ld_sel;
   logic [WIDTH-1:0] ld_data;
   logic             ld_ready;

   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [AW-1:0]    rs_sel;
   logic [AW-1:0]    rt_sel;
   logic [AW-1:0]    rd_sel;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_rd;
   logic [AW-1:0]    out_rd_sel;
   logic             out_carry;
   logic             out_zero;

   modport master (
      output ld_en, ld_sel, ld_data,
      output in_valid, op, rs_sel, rt_sel, rd_sel,
      output out_ready,
      input  ld_ready, in_ready,
      input  out_valid, out_rd, out_rd_sel, out_carry, out_zero
   );

   modport slave (
      input  ld_en, ld_sel, ld_data,
      input  in_valid, op, rs_sel, rt_sel, rd_sel,
      input  out_ready,
      output ld_ready, in_ready,
      output out_valid, out_rd, out_rd_sel, out_carry, out_zero
   );
endinterface

// File: rtl/decode_execute_pipe.sv
// Two-stage decode/execute pipeline over an NREG x WIDTH register file. Writeback happens
// on the D->X edge, so a back-to-back dependent instruction reads the fresh value directly.
module decode_execute_pipe #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned NREG      = 4,
   parameter bit          SIGNED_LT = 1'b0
) (
   input logic                 clk,
   input logic                 rst,
   decode_execute_pipe_if.slave bus
);
   localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;

   // Decode stage
   logic             d_valid_q, d_valid_d;
   logic [2:0]       d_op_q, d_op_d;
   logic [AW-1:0]    d_rs_q, d_rs_d;
   logic [AW-1:0]    d_rt_q, d_rt_d;
   logic [AW-1:0]    d_rd_q, d_rd_d;

   // Execute stage
   logic             x_valid_q, x_valid_d;
   logic [WIDTH-1:0] x_rd_q, x_rd_d;
   logic [AW-1:0]    x_rd_sel_q, x_rd_sel_d;
   logic             x_carry_q, x_carry_d;
   logic             x_zero_q, x_zero_d;

   logic [WIDTH-1:0] rf_q [NREG];
   logic [WIDTH-1:0] rf_d [NREG];

   logic             advance;
   logic             accept;
   logic             ld_fire;
   logic             in_ready;
   logic             ld_ready;

   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic             lt;
   logic             eq;

   // Handshake control
   always_comb begin
      advance  = d_valid_q & (~x_valid_q | bus.out_ready);
      in_ready = ~rst & ~bus.ld_en & (~d_valid_q | advance);
      ld_ready = ~rst & ~d_valid_q & ~x_valid_q;
      accept   = bus.in_valid & in_ready;
      ld_fire  = bus.ld_en & ld_ready;
   end

   // Execute datapath; operands are the pre-write register contents
   always_comb begin
      rs_val = rf_q[d_rs_q];
      rt_val = rf_q[d_rt_q];
      lt     = SIGNED_LT ? ($signed(rs_val) < $signed(rt_val)) : (rs_val < rt_val);
      eq     = (rs_val == rt_val);
      sum    = '0;
      res    = '0;
      carry  = 1'b0;
      unique case (d_op_q)
         3'b000: begin
            sum   = {1'b0, rs_val} + {1'b0, ~rt_val} + {{WIDTH{1'b0}}, 1'b1};
            res   = sum[WIDTH-1:0];
            carry = sum[WIDTH];
         end
         3'b001: begin
            sum   = {1'b0, rs_val} + {1'b0, rt_val};
            res   = sum[WIDTH-1:0];
            carry = sum[WIDTH];
         end
         3'b010: res = rs_val | rt_val;
         3'b011: res = rs_val & rt_val;
         3'b100: begin
            res   = {rt_val[WIDTH-1], rt_val[WIDTH-1:1]};
            carry = rt_val[0];
         end
         3'b101: begin
            res   = {rs_val[WIDTH-2:0], rs_val[WIDTH-1]};
            carry = rs_val[WIDTH-1];
         end
         3'b110: res = {{(WIDTH-1){1'b0}}, lt};
         3'b111: res = {{(WIDTH-1){1'b0}}, eq};
      endcase
   end

   // Stage next-state
   always_comb begin
      d_valid_d = d_valid_q;
      d_op_d    = d_op_q;
      d_rs_d    = d_rs_q;
      d_rt_d    = d_rt_q;
      d_rd_d    = d_rd_q;
      if (accept) begin
         d_valid_d = 1'b1;
         d_op_d    = bus.op;
         d_rs_d    = bus.rs_sel;
         d_rt_d    = bus.rt_sel;
         d_rd_d    = bus.rd_sel;
      end else if (advance) begin
         d_valid_d = 1'b0;
      end

      x_valid_d  = x_valid_q;
      x_rd_d     = x_rd_q;
      x_rd_sel_d = x_rd_sel_q;
      x_carry_d  = x_carry_q;
      x_zero_d   = x_zero_q;
      if (advance) begin
         x_valid_d  = 1'b1;
         x_rd_d     = res;
         x_rd_sel_d = d_rd_q;
         x_carry_d  = carry;
         x_zero_d   = (res == '0);
      end else if (x_valid_q & bus.out_ready) begin
         x_valid_d = 1'b0;
      end
   end

   // Register-file next-state; loads and writeback never coincide since loads need D empty
   always_comb begin
      rf_d = rf_q;
      if (ld_fire) rf_d[bus.ld_sel] = bus.ld_data;
      if (advance) rf_d[d_rd_q] = res;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d_valid_q  <= 1'b0;
         d_op_q     <= '0;
         d_rs_q     <= '0;
         d_rt_q     <= '0;
         d_rd_q     <= '0;
         x_valid_q  <= 1'b0;
         x_rd_q     <= '0;
         x_rd_sel_q <= '0;
         x_carry_q  <= 1'b0;
         x_zero_q   <= 1'b0;
      end else begin
         d_valid_q  <= d_valid_d;
         d_op_q     <= d_op_d;
         d_rs_q     <= d_rs_d;
         d_rt_q     <= d_rt_d;
         d_rd_q     <= d_rd_d;
         x_valid_q  <= x_valid_d;
         x_rd_q     <= x_rd_d;
         x_rd_sel_q <= x_rd_sel_d;
         x_carry_q  <= x_carry_d;
         x_zero_q   <= x_zero_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
      end else begin
         for (int i = 0; i < int'(NREG); i++) rf_q[i] <= rf_d[i];
      end
   end

   always_comb begin
      bus.in_ready   = in_ready;
      bus.ld_ready   = ld_ready;
      bus.out_valid  = x_valid_q;
      bus.out_rd     = x_rd_q;
      bus.out_rd_sel = x_rd_sel_q;
      bus.out_carry  = x_carry_q;
      bus.out_zero   = x_zero_q;
   end

   // A stalled result must not change underneath the consumer
   a_out_stable: assert property (@(posedge clk) disable iff (rst)
      (x_valid_q && !bus.out_ready) |=> (x_valid_q && $stable(x_rd_q) && $stable(x_rd_sel_q)
                                         && $stable(x_carry_q) && $stable(x_zero_q)));

   a_no_ld_when_busy: assert property (@(posedge clk) disable iff (rst)
      ld_fire |-> (!advance && !accept));

endmodule

// File: tb/tb_decode_execute_pipe.sv
// Directed bench for decode_execute_pipe: one task per scenario with hand-computed results.
module tb_decode_execute_pipe;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   decode_execute_pipe_if #(.WIDTH(8), .NREG(4)) bus ();
   decode_execute_pipe_if #(.WIDTH(8), .NREG(4)) bus2 ();

   decode_execute_pipe #(.WIDTH(8), .NREG(4), .SIGNED_LT(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   decode_execute_pipe #(.WIDTH(8), .NREG(4), .SIGNED_LT(1'b1)) dut_signed (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [1:0] sel, input logic [7:0] data);
      bus.ld_en   = 1'b1;
      bus.ld_sel  = sel;
      bus.ld_data = data;
      tick();
      bus.ld_en   = 1'b0;
   endtask

   task automatic load2(input logic [1:0] sel, input logic [7:0] data);
      bus2.ld_en   = 1'b1;
      bus2.ld_sel  = sel;
      bus2.ld_data = data;
      tick();
      bus2.ld_en   = 1'b0;
   endtask

   task automatic set_instr(input logic [2:0] o, input logic [1:0] s, input logic [1:0] t,
                            input logic [1:0] d);
      bus.in_valid = 1'b1;
      bus.op       = o;
      bus.rs_sel   = s;
      bus.rt_sel   = t;
      bus.rd_sel   = d;
   endtask

   // Issue one instruction into an empty pipe, sample its result, then drain it.
   task automatic run_op(input logic [2:0] o, input logic [1:0] s, input logic [1:0] t,
                         input logic [1:0] d, output logic [7:0] r, output logic c,
                         output logic z, output logic [1:0] sel);
      bus.out_ready = 1'b1;
      set_instr(o, s, t, d);
      tick();
      bus.in_valid = 1'b0;
      tick();
      r   = bus.out_rd;
      c   = bus.out_carry;
      z   = bus.out_zero;
      sel = bus.out_rd_sel;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++;
         $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
      n_checks++; if (bus.ld_ready !== 1'b0) begin n_errors++;
         $display("FAIL reset_ld_ready: got %b want 0", bus.ld_ready); end
      n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++;
         $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_checks++; if ({bus.out_rd, bus.out_rd_sel, bus.out_carry, bus.out_zero} !== 12'h000)
         begin n_errors++;
         $display("FAIL reset_outputs: got rd=%h sel=%0d c=%b z=%b want all 0",
                  bus.out_rd, bus.out_rd_sel, bus.out_carry, bus.out_zero); end
      rst = 1'b0;
      #1;
      n_checks++; if (bus.ld_ready !== 1'b1 || bus.in_ready !== 1'b1) begin n_errors++;
         $display("FAIL post_reset_ready: got ld=%b in=%b want 1 1", bus.ld_ready,
                  bus.in_ready); end
   endtask

   task automatic test_add();
      load(2'd0, 8'h05);
      load(2'd1, 8'h03);
      bus.out_ready = 1'b1;
      set_instr(3'b001, 2'd0, 2'd1, 2'd2);
      tick();
      bus.in_valid = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++;
         $display("FAIL add_latency_early: out_valid got %b want 0", bus.out_valid); end
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 8'h08 || bus.out_rd_sel !== 2'd2)
         begin n_errors++;
         $display("FAIL add_result: got v=%b rd=%h sel=%0d want v=1 rd=08 sel=2",
                  bus.out_valid, bus.out_rd, bus.out_rd_sel); end
      n_checks++; if (bus.out_carry !== 1'b0 || bus.out_zero !== 1'b0) begin n_errors++;
         $display("FAIL add_flags: got c=%b z=%b want 0 0", bus.out_carry, bus.out_zero); end
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++;
         $display("FAIL add_drain: out_valid got %b want 0", bus.out_valid); end
   endtask

   task automatic test_arith();
      logic [7:0] r;
      logic       c, z;
      logic [1:0] sel;
      run_op(3'b000, 2'd1, 2'd0, 2'd3, r, c, z, sel);
      n_checks++; if (r !== 8'hFE || c !== 1'b0 || z !== 1'b0 || sel !== 2'd3) begin
         n_errors++;
         $display("FAIL sub_borrow: got rd=%h c=%b z=%b sel=%0d want FE 0 0 3", r, c, z, sel);
      end
      load(2'd0, 8'hFF);
      load(2'd1, 8'h01);
      run_op(3'b001, 2'd0, 2'd1, 2'd2, r, c, z, sel);
      n_checks++; if (r !== 8'h00 || c !== 1'b1 || z !== 1'b1) begin n_errors++;
         $display("FAIL add_wrap: got rd=%h c=%b z=%b want 00 1 1", r, c, z); end
      // Self-subtract: all rs/rt/rd equal, operands are pre-write values
      run_op(3'b000, 2'd0, 2'd0, 2'd0, r, c, z, sel);
      n_checks++; if (r !== 8'h00 || c !== 1'b1 || z !== 1'b1) begin n_errors++;
         $display("FAIL sub_self: got rd=%h c=%b z=%b want 00 1 1", r, c, z); end
      run_op(3'b011, 2'd1, 2'd3, 2'd2, r, c, z, sel);
      n_checks++; if (r !== 8'h00 || z !== 1'b1) begin n_errors++;
         $display("FAIL and_zero: got rd=%h z=%b want 00 1", r, z); end
   endtask

   task automatic test_back_to_back();
      load(2'd0, 8'h05);
      load(2'd1, 8'h03);
      bus.out_ready = 1'b1;
      set_instr(3'b001, 2'd0, 2'd1, 2'd2);
      tick();
      set_instr(3'b001, 2'd2, 2'd2, 2'd3);
      n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++;
         $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 8'h08 || bus.out_rd_sel !== 2'd2)
         begin n_errors++;
         $display("FAIL b2b_first: got v=%b rd=%h sel=%0d want 1 08 2", bus.out_valid,
                  bus.out_rd, bus.out_rd_sel); end
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 8'h10 || bus.out_rd_sel !== 2'd3)
         begin n_errors++;
         $display("FAIL b2b_second: got v=%b rd=%h sel=%0d want 1 10 3", bus.out_valid,
                  bus.out_rd, bus.out_rd_sel); end
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++;
         $display("FAIL b2b_drain: out_valid got %b want 0", bus.out_valid); end
   endtask

   // Regs: R0=05 R1=03 R2=08 R3=10. A: R0+R1->R2=08, B: R0|R3->R3=15, C: R2&R3->R0=00.
   task automatic test_backpressure();
      int accepts;
      accepts = 0;
      bus.out_ready = 1'b0;
      set_instr(3'b001, 2'd0, 2'd1, 2'd2);
      if (bus.in_ready === 1'b1) accepts++;
      tick();
      set_instr(3'b010, 2'd0, 2'd3, 2'd3);
      if (bus.in_ready === 1'b1) accepts++;
      tick();
      set_instr(3'b011, 2'd2, 2'd3, 2'd0);
      n_checks++; if (bus.in_ready !== 1'b0) begin n_errors++;
         $display("FAIL bp_in_ready_drop: got %b want 0", bus.in_ready); end
      n_checks++; if (accepts != 2) begin n_errors++;
         $display("FAIL bp_accepts: got %0d want 2", accepts); end
      tick();
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 8'h08 || bus.out_rd_sel !== 2'd2)
         begin n_errors++;
         $display("FAIL bp_stable: got v=%b rd=%h sel=%0d want 1 08 2", bus.out_valid,
                  bus.out_rd, bus.out_rd_sel); end
      bus.out_ready = 1'b1;
      #1;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_errors++;
         $display("FAIL bp_in_ready_release: got %b want 1", bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 8'h15 || bus.out_rd_sel !== 2'd3)
         begin n_errors++;
         $display("FAIL bp_second: got v=%b rd=%h sel=%0d want 1 15 3", bus.out_valid,
                  bus.out_rd, bus.out_rd_sel); end
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 8'h00 || bus.out_zero !== 1'b1
                      || bus.out_rd_sel !== 2'd0) begin n_errors++;
         $display("FAIL bp_third: got v=%b rd=%h z=%b sel=%0d want 1 00 1 0", bus.out_valid,
                  bus.out_rd, bus.out_zero, bus.out_rd_sel); end
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++;
         $display("FAIL bp_no_duplicate: out_valid got %b want 0", bus.out_valid); end
   endtask

   task automatic test_shift_cmp();
      logic [7:0] r;
      logic       c, z;
      logic [1:0] sel;
      load(2'd0, 8'h80);
      load(2'd1, 8'h81);
      load(2'd2, 8'h03);
      load(2'd3, 8'h05);
      run_op(3'b100, 2'd3, 2'd0, 2'd0, r, c, z, sel);
      n_checks++; if (r !== 8'hC0 || c !== 1'b0) begin n_errors++;
         $display("FAIL asr_neg: got rd=%h c=%b want C0 0", r, c); end
      run_op(3'b101, 2'd1, 2'd3, 2'd1, r, c, z, sel);
      n_checks++; if (r !== 8'h03 || c !== 1'b1) begin n_errors++;
         $display("FAIL rol: got rd=%h c=%b want 03 1", r, c); end
      run_op(3'b100, 2'd0, 2'd2, 2'd0, r, c, z, sel);
      n_checks++; if (r !== 8'h01 || c !== 1'b1) begin n_errors++;
         $display("FAIL asr_pos: got rd=%h c=%b want 01 1", r, c); end
      run_op(3'b110, 2'd2, 2'd3, 2'd0, r, c, z, sel);
      n_checks++; if (r !== 8'h01 || c !== 1'b0 || z !== 1'b0) begin n_errors++;
         $display("FAIL lt_true: got rd=%h c=%b z=%b want 01 0 0", r, c, z); end
      run_op(3'b111, 2'd2, 2'd3, 2'd0, r, c, z, sel);
      n_checks++; if (r !== 8'h00 || z !== 1'b1) begin n_errors++;
         $display("FAIL eq_false: got rd=%h z=%b want 00 1", r, z); end
      run_op(3'b111, 2'd2, 2'd2, 2'd0, r, c, z, sel);
      n_checks++; if (r !== 8'h01 || z !== 1'b0) begin n_errors++;
         $display("FAIL eq_true: got rd=%h z=%b want 01 0", r, z); end
      run_op(3'b010, 2'd2, 2'd3, 2'd0, r, c, z, sel);
      n_checks++; if (r !== 8'h07 || c !== 1'b0) begin n_errors++;
         $display("FAIL or: got rd=%h c=%b want 07 0", r, c); end
      // 0x80 < 0x01 is false unsigned, true signed
      load(2'd0, 8'h80);
      load(2'd1, 8'h01);
      run_op(3'b110, 2'd0, 2'd1, 2'd2, r, c, z, sel);
      n_checks++; if (r !== 8'h00 || z !== 1'b1) begin n_errors++;
         $display("FAIL lt_unsigned: got rd=%h z=%b want 00 1", r, z); end
   endtask

   task automatic test_signed_lt();
      load2(2'd0, 8'h80);
      load2(2'd1, 8'h01);
      bus2.out_ready = 1'b1;
      bus2.in_valid  = 1'b1;
      bus2.op        = 3'b110;
      bus2.rs_sel    = 2'd0;
      bus2.rt_sel    = 2'd1;
      bus2.rd_sel    = 2'd2;
      tick();
      bus2.in_valid = 1'b0;
      tick();
      n_checks++; if (bus2.out_valid !== 1'b1 || bus2.out_rd !== 8'h01 || bus2.out_zero !== 1'b0)
         begin n_errors++;
         $display("FAIL lt_signed: got v=%b rd=%h z=%b want 1 01 0", bus2.out_valid,
                  bus2.out_rd, bus2.out_zero); end
      tick();
   endtask

   task automatic test_reset_inflight();
      logic [7:0] r;
      logic       c, z;
      logic [1:0] sel;
      load(2'd0, 8'h5A);
      load(2'd1, 8'h21);
      bus.out_ready = 1'b0;
      set_instr(3'b001, 2'd0, 2'd1, 2'd2);
      tick();
      set_instr(3'b010, 2'd0, 2'd1, 2'd3);
      tick();
      // D and X both full; also present a load and a new instruction during reset
      set_instr(3'b001, 2'd0, 2'd0, 2'd1);
      bus.ld_en   = 1'b1;
      bus.ld_sel  = 2'd0;
      bus.ld_data = 8'hAA;
      rst = 1'b1;
      #1;
      n_checks++; if (bus.in_ready !== 1'b0 || bus.ld_ready !== 1'b0) begin n_errors++;
         $display("FAIL rst_ready_low: got in=%b ld=%b want 0 0", bus.in_ready, bus.ld_ready);
      end
      tick();
      rst = 1'b0;
      bus.ld_en    = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      n_checks++; if (bus.out_valid !== 1'b0 || bus.ld_ready !== 1'b1 || bus.out_rd !== 8'h00)
         begin n_errors++;
         $display("FAIL rst_flush: got v=%b ld=%b rd=%h want 0 1 00", bus.out_valid,
                  bus.ld_ready, bus.out_rd); end
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) begin n_errors++;
         $display("FAIL rst_discard: out_valid got %b want 0", bus.out_valid); end
      run_op(3'b010, 2'd0, 2'd1, 2'd2, r, c, z, sel);
      n_checks++; if (r !== 8'h00 || z !== 1'b1) begin n_errors++;
         $display("FAIL rst_regfile: got rd=%h z=%b want 00 1", r, z); end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      bus.ld_en = 1'b0; bus.ld_sel = '0; bus.ld_data = '0;
      bus.in_valid = 1'b0; bus.op = '0; bus.rs_sel = '0; bus.rt_sel = '0; bus.rd_sel = '0;
      bus.out_ready = 1'b0;
      bus2.ld_en = 1'b0; bus2.ld_sel = '0; bus2.ld_data = '0;
      bus2.in_valid = 1'b0; bus2.op = '0; bus2.rs_sel = '0; bus2.rt_sel = '0;
      bus2.rd_sel = '0; bus2.out_ready = 1'b0;

      test_reset();
      test_add();
      test_arith();
      test_back_to_back();
      test_backpressure();
      test_shift_cmp();
      test_signed_lt();
      test_reset_inflight();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/decode_execute_pipe.md
DECODE_EXECUTE_PIPE -- requirements
Module: decode_execute_pipe

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; the block SHALL support any WIDTH of 2 or more.
REQ-002 Parameter: NREG, default 4, register-file depth; the block SHALL support any power of 2 from 2 upward; AW = log2(NREG) is derived.
REQ-003 Parameter: SIGNED_LT, default 0; value 1 SHALL make op 110 a two's-complement compare, value 0 an unsigned compare.
REQ-004 Single clock, reset synchronous and active-high; ports are listed below.
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- ld_en  in  1  register-file load request
- ld_sel  in  AW  load target register
- ld_data  in  WIDTH  load value
- ld_ready  out  1  load accepted this cycle when high
- in_valid  in  1  instruction valid
- in_ready  out  1  instruction accepted on in_valid & in_ready
- op  in  3  opcode
- rs_sel, rt_sel, rd_sel  in  AW each  source/destination registers
- out_valid  out  1  result valid
- out_ready  in  1  result consumed on out_valid & out_ready
- out_rd  out  WIDTH  result value
- out_rd_sel  out  AW  destination of result
- out_carry  out  1  carry flag
- out_zero  out  1  result == 0

Function
REQ-005 The block SHALL contain an NREG x WIDTH register file and a two-stage pipeline: stage D (decoded instruction: op, rs_sel, rt_sel, rd_sel, valid) and stage X (result: out_* registers, valid).
REQ-006 D SHALL advance into X when D is valid and (X is empty or out_ready = 1).
REQ-007 On that advance, operands SHALL be read from the register file, the result computed, X loaded, and regfile[rd_sel] written, all at the same edge.
REQ-008 in_ready SHALL be !ld_en & (D empty | D advances this cycle); this is combinational from out_ready.
REQ-009 Latency: an instruction accepted at edge t SHALL show out_valid = 1 after edge t+1. With out_ready held at 1, throughput SHALL be one instruction per cycle.
REQ-010 Dependent instructions issued back-to-back SHALL read the value written by the older instruction, with no stall and no forwarding logic.
REQ-011 While out_valid = 1 and out_ready = 0, out_rd, out_rd_sel, out_carry and out_zero SHALL stay stable. D SHALL hold and no instruction SHALL be lost.
REQ-012 X SHALL empty on out_valid & out_ready when D does not advance in the same cycle.
REQ-013 Opcodes, all results truncated to WIDTH:
- 000 rs-rt, computed as rs+~rt+1; carry = carry-out (1 means no borrow)
- 001 rs+rt; carry = carry-out
- 010 rs|rt; carry = 0
- 011 rs&rt; carry = 0
- 100 rt arithmetic right shift by 1 (MSB replicated); carry = rt[0]
- 101 rs rotate left by 1; carry = rs[WIDTH-1]
- 110 rs<rt (signedness per SIGNED_LT), zero-extended to WIDTH; carry = 0
- 111 rs==rt, zero-extended to WIDTH; carry = 0
REQ-014 out_zero SHALL equal (result == 0) for every opcode.
REQ-015 ld_ready SHALL be (D empty & X empty). When ld_en & ld_ready, regfile[ld_sel] SHALL take ld_data at that edge. ld_en while ld_ready = 0 SHALL have no effect.
REQ-016 rs_sel, rt_sel and rd_sel SHALL be allowed to be equal; the operands read SHALL be the pre-write values.

Reset
REQ-017 While rst = 1 at a clock edge, all of the following SHALL clear to 0: D valid, X valid (out_valid), out_rd, out_rd_sel, out_carry, out_zero and every register-file entry.
REQ-018 Reset SHALL override any same-cycle load, instruction accept or writeback; in-flight instructions SHALL be discarded.
REQ-019 During reset, in_ready and ld_ready SHALL be 0.

Verification (WIDTH=8, NREG=4, SIGNED_LT=0)
REQ-020 Load R0=0x05, R1=0x03, then ADD R2=R0+R1 -> out_valid two edges after accept; out_rd=0x08, out_rd_sel=2, carry=0, zero=0.
REQ-021 Arithmetic boundaries:
- R1-R0 (0x03-0x05) -> 0xFE, carry=0
- load 0xFF and 0x01, then ADD -> 0x00, carry=1, zero=1
REQ-022 Dependency chain: ADD R2=R0+R1, then ADD R3=R2+R2 on the next cycle, out_ready=1 -> results 0x08 then 0x10 on consecutive cycles.
REQ-023 Backpressure: issue 3 instructions with out_ready=0 -> in_ready drops after 2 accepts and out_rd stays stable. Raising out_ready -> all 3 results in order, none dropped or duplicated.
REQ-024 Shifts and compares:
- op 100 on rt=0x80 -> 0xC0, carry=0
- op 101 on rs=0x81 -> 0x03, carry=1
- op 110 with 0x03<0x05 -> 0x01; op 111 on the same pair -> 0x00
- with SIGNED_LT=1, op 110 with 0x80<0x01 -> 0x01
REQ-025 Assert rst for one cycle with D and X both full -> after that edge out_valid=0, ld_ready=1, and a subsequent op 010 (OR) of R0|R1 -> 0x00.
